shiftx_sched: RTL and testbench
===============================

# shiftx_sched

Two-requester scheduler for the shared `shiftx` cell with information-flow-tracking (IFT) taint propagation. It arbitrates round-robin between two valid/ready requesters and latches the winner's operands and taints. It evaluates the `shiftx` function (logical right shift, out-of-range bits undefined) with taint rules, then holds the tagged result until the consumer accepts it. It sits in front of the IFT test-cell datapath as the single owner of the shifter resource.

## Interface
- `WIDTH`, 2, data width of A and Y.
- `SHW`, 2, width of shift amount B (unsigned).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0_valid` input 1: requester 0 has an operation.
- `req0_ready` output 1: requester 0 operation accepted this cycle.
- `req0_a` input WIDTH: requester 0 operand A.
- `req0_a_t` input WIDTH: requester 0 per-bit taint of A.
- `req0_b` input SHW: requester 0 shift amount.
- `req0_b_t` input SHW: requester 0 per-bit taint of B.
- `req1_*` has the same set and widths as `req0_*`, for requester 1.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_y` output WIDTH: shift result; undefined bits are driven 0.
- `out_y_t` output WIDTH: result taint.
- `out_xmask` output WIDTH: 1 marks a bit `shiftx` defines as x.
- `out_id` output 1: requester that issued the result.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, EXEC, DONE.
- **IDLE**
  - If any `reqN_valid` is high, grant one requester.
  - The granted `reqN_ready` is 1 for exactly this cycle, combinationally from state and valids.
  - Latch `a`, `a_t`, `b`, `b_t` and the id, then go to EXEC.
  - With no request, stay in IDLE.
- **Arbitration**
  - Round-robin pointer `last`, reset value 1, so requester 0 wins first.
  - If both are valid, grant the requester that is not `last`.
  - If only one is valid, grant it.
  - `last` updates on every grant.
- **EXEC**
  - Compute the result into output registers, then go to DONE unconditionally.
  - For each bit i, with `k = i + b` computed at SHW+clog2(WIDTH)+1 bits so there is no wrap:
    - If `k < WIDTH`: `y[i] = a[k]`, `xmask[i] = 0`, `y_t[i] = a_t[k] | (|b_t)`.
    - Else: `y[i] = 0`, `xmask[i] = 1`, `y_t[i] = |b_t`.
  - `b >= WIDTH` gives all-x, `y = 0`, and `y_t` set to all ones only if B is tainted.
  - Any tainted bit of B taints every output bit.
- **DONE**
  - `out_valid = 1`; outputs are held stable.
  - When `out_ready` is 1, the transfer completes and the FSM returns to IDLE.
  - No new grant is issued in the completion cycle.
- `reqN_ready` is 0 in EXEC and DONE. Requests pending there are arbitrated on the next IDLE cycle.
- **Reset** (asynchronous, any state)
  - State returns to IDLE and `last` to 1.
  - `out_valid`, `out_y`, `out_y_t`, `out_xmask`, `out_id`, `busy` and both `reqN_ready` go to 0.
  - An in-flight operation is discarded and is not replayed.

## Timing
- Accept at edge N (IDLE, ready high). State is EXEC after N, DONE after N+1.
- `out_valid` is high starting in the cycle after edge N+1, which is 2 cycles of latency.
- With `out_ready` tied high, the minimum cycle per op is 3 edges: accept, exec, complete. Back-to-back accept happens on the edge after completion.
- `out_*` change only on the EXEC->DONE edge or at reset.
- A requester may drop `valid` without a handshake while not granted; nothing is latched.
- Requester data need only be stable in its ready cycle.

## Test plan
- Reset, then idle: all outputs 0, `busy` 0, and no ready pulses for 5 cycles.
- Req0 sends `a=2'b10`, `b=1`, untainted: `out_y=2'b01`, `out_xmask=2'b10`, `out_y_t=0`, `out_id=0`, `out_valid` 2 cycles after accept.
- Taint propagation:
  - `a=2'b11`, `a_t=2'b10`, `b=1`, `b_t=0` gives `y=2'b01`, `y_t=2'b01`, `xmask=2'b10`.
  - The same operation with `b_t=2'b01` gives `y_t=2'b11`.
  - `b=3` (≥WIDTH) gives `y=0`, `xmask=2'b11`, and `y_t=0` if untainted.
- Both requesters continuously valid with `out_ready` high: grants alternate 0,1,0,1 across four ops, matched by `out_id`, with a ready pulse every 3 cycles.
- Backpressure: `out_ready` low for 4 cycles in DONE keeps outputs stable and both readies 0. Raising `out_ready` completes the op, and the next grant follows one cycle later.
- Assert `rst_n` low during EXEC: outputs clear immediately, and after release req0 wins first even if req1 was `last`.

Source files
------------

// File: rtl/shiftx_sched.sv
// rtl/shiftx_sched.sv - round-robin scheduler for the shared shiftx cell with IFT taint tracking
module shiftx_sched #(
   parameter int WIDTH = 2,
   parameter int SHW   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_a_t,
   input  logic [SHW-1:0]   req0_b,
   input  logic [SHW-1:0]   req0_b_t,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_a_t,
   input  logic [SHW-1:0]   req1_b,
   input  logic [SHW-1:0]   req1_b_t,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic [WIDTH-1:0] out_y_t,
   output logic [WIDTH-1:0] out_xmask,
   output logic             out_id,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic             last_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] a_t_q;
   logic [SHW-1:0]   b_q;
   logic [SHW-1:0]   b_t_q;
   logic             id_q;

   logic             out_valid_q;
   logic [WIDTH-1:0] out_y_q;
   logic [WIDTH-1:0] out_y_t_q;
   logic [WIDTH-1:0] out_xmask_q;
   logic             out_id_q;
   logic             busy_q;

   logic             any_valid;
   logic             grant_id;
   logic             gnt0;
   logic             gnt1;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_a_t;
   logic [SHW-1:0]   sel_b;
   logic [SHW-1:0]   sel_b_t;

   logic [WIDTH-1:0] y_d;
   logic [WIDTH-1:0] y_t_d;
   logic [WIDTH-1:0] xmask_d;

   // Round-robin pick: on contention the requester that did not win last time goes next.
   // Ready is gated by rst_n so no handshake can be seen while reset is asserted.
   always_comb begin
      any_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_id = ~last_q;
      end else begin
         grant_id = req1_valid;
      end
      gnt0    = rst_n && (state_q == IDLE) && any_valid && !grant_id;
      gnt1    = rst_n && (state_q == IDLE) && any_valid &&  grant_id;
      sel_a   = grant_id ? req1_a   : req0_a;
      sel_a_t = grant_id ? req1_a_t : req0_a_t;
      sel_b   = grant_id ? req1_b   : req0_b;
      sel_b_t = grant_id ? req1_b_t : req0_b_t;
   end

   // shiftx evaluation: result bit i reads a[i+b]; positions past the top of A are x.
   // A logical right shift never wraps, so b >= WIDTH yields all-x with y = 0.
   // Any tainted bit of the shift amount taints every result bit.
   always_comb begin
      y_d     = a_q >> b_q;
      xmask_d = ~({WIDTH{1'b1}} >> b_q);
      y_t_d   = (a_t_q >> b_q) | {WIDTH{|b_t_q}};
   end

   // Control FSM with operand latches and registered result/handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         a_q         <= '0;
         a_t_q       <= '0;
         b_q         <= '0;
         b_t_q       <= '0;
         id_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_y_t_q   <= '0;
         out_xmask_q <= '0;
         out_id_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  a_q     <= sel_a;
                  a_t_q   <= sel_a_t;
                  b_q     <= sel_b;
                  b_t_q   <= sel_b_t;
                  id_q    <= grant_id;
                  last_q  <= grant_id;
                  busy_q  <= 1'b1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               out_y_q     <= y_d;
               out_y_t_q   <= y_t_d;
               out_xmask_q <= xmask_d;
               out_id_q    <= id_q;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign out_valid  = out_valid_q;
   assign out_y      = out_y_q;
   assign out_y_t    = out_y_t_q;
   assign out_xmask  = out_xmask_q;
   assign out_id     = out_id_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_shiftx_sched.sv
// tb/tb_shiftx_sched.sv - self-checking bench for shiftx_sched
module tb_shiftx_sched;

   localparam int W = 2;
   localparam int S = 2;

   logic         clk;
   logic         rst_n;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0] req0_a, req0_a_t, req1_a, req1_a_t;
   logic [S-1:0] req0_b, req0_b_t, req1_b, req1_b_t;
   logic         out_valid, out_ready, out_id, busy;
   logic [W-1:0] out_y, out_y_t, out_xmask;

   int vectors;
   int miscompares;

   shiftx_sched #(.WIDTH(W), .SHW(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_a_t   (req0_a_t),
      .req0_b     (req0_b),
      .req0_b_t   (req0_b_t),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_a_t   (req1_a_t),
      .req1_b     (req1_b),
      .req1_b_t   (req1_b_t),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_y_t    (out_y_t),
      .out_xmask  (out_xmask),
      .out_id     (out_id),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   typedef struct {
      logic         id;
      logic [W-1:0] a;
      logic [W-1:0] at;
      logic [S-1:0] b;
      logic [S-1:0] bt;
      logic [W-1:0] ey;
      logic [W-1:0] eyt;
      logic [W-1:0] exm;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Reference: bit i of the result reads a[i+b] when that index exists, otherwise it is x.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] at,
                                 input logic [S-1:0] b, input logic [S-1:0] bt,
                                 output logic [W-1:0] y, output logic [W-1:0] yt,
                                 output logic [W-1:0] xm);
      logic [W-1:0] sa;
      logic [W-1:0] st;
      logic         bt_any;
      bt_any = |bt;
      y  = '0;
      yt = '0;
      xm = '0;
      for (int i = 0; i < W; i++) begin
         int k;
         k = i + int'(b);
         if (k < W) begin
            sa = a >> k;
            st = at >> k;
            y  = y  | (W'(sa[0]) << i);
            yt = yt | (W'(st[0] | bt_any) << i);
         end else begin
            xm = xm | (W'(1) << i);
            yt = yt | (W'(bt_any) << i);
         end
      end
   endfunction

   task automatic drive_req(input logic id, input logic v, input logic [W-1:0] a, input logic [W-1:0] at,
                            input logic [S-1:0] b, input logic [S-1:0] bt);
      if (!id) begin
         req0_valid = v; req0_a = a; req0_a_t = at; req0_b = b; req0_b_t = bt;
      end else begin
         req1_valid = v; req1_a = a; req1_a_t = at; req1_b = b; req1_b_t = bt;
      end
   endtask

   // One operation from a single requester; DUT must be idle on entry and is idle on return.
   task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] at,
                         input logic [S-1:0] b, input logic [S-1:0] bt,
                         input logic [W-1:0] ey, input logic [W-1:0] eyt, input logic [W-1:0] exm,
                         input int stall, input int idx);
      @(negedge clk);
      drive_req(id, 1'b1, a, at, b, bt);
      #1;
      chk("op_ready_own", idx, 32'(id ? req1_ready : req0_ready), 32'(1));
      chk("op_ready_other", idx, 32'(id ? req0_ready : req1_ready), 32'(0));
      @(posedge clk);
      #1;
      drive_req(id, 1'b0, W'($urandom), W'($urandom), S'($urandom), S'($urandom));
      @(negedge clk);
      chk("op_exec_valid", idx, 32'(out_valid), 32'(0));
      chk("op_exec_busy", idx, 32'(busy), 32'(1));
      @(negedge clk);
      chk("op_done_valid", idx, 32'(out_valid), 32'(1));
      chk("op_y", idx, 32'(out_y), 32'(ey));
      chk("op_yt", idx, 32'(out_y_t), 32'(eyt));
      chk("op_xmask", idx, 32'(out_xmask), 32'(exm));
      chk("op_id", idx, 32'(out_id), 32'(id));
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("op_stall_valid", idx, 32'(out_valid), 32'(1));
         chk("op_stall_y", idx, 32'({out_y, out_y_t, out_xmask}), 32'({ey, eyt, exm}));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("op_post_valid", idx, 32'(out_valid), 32'(0));
      chk("op_post_busy", idx, 32'(busy), 32'(0));
      chk("op_post_hold_y", idx, 32'(out_y), 32'(ey));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int           g_id[$];
      int           g_cyc[$];
      int           o_id[$];
      logic [W-1:0] o_y[$];
      logic [W-1:0] ry, ryt, rxm;
      logic [W-1:0] e0y, e0yt, e0xm, e1y, e1yt, e1xm;
      logic         rid;
      logic [W-1:0] ra, rat;
      logic [S-1:0] rb, rbt;

      vectors = 0;
      miscompares = 0;
      rst_n = 1'b1;
      out_ready = 1'b0;
      drive_req(1'b0, 1'b0, '0, '0, '0, '0);
      drive_req(1'b1, 1'b0, '0, '0, '0, '0);

      tbl[0] = '{1'b0, 2'b10, 2'b00, 2'd1, 2'b00, 2'b01, 2'b00, 2'b10};
      tbl[1] = '{1'b1, 2'b11, 2'b10, 2'd1, 2'b00, 2'b01, 2'b01, 2'b10};
      tbl[2] = '{1'b0, 2'b11, 2'b10, 2'd1, 2'b01, 2'b01, 2'b11, 2'b10};
      tbl[3] = '{1'b1, 2'b11, 2'b11, 2'd3, 2'b00, 2'b00, 2'b00, 2'b11};
      tbl[4] = '{1'b0, 2'b11, 2'b00, 2'd3, 2'b10, 2'b00, 2'b11, 2'b11};
      tbl[5] = '{1'b1, 2'b10, 2'b01, 2'd0, 2'b00, 2'b10, 2'b01, 2'b00};
      tbl[6] = '{1'b0, 2'b11, 2'b11, 2'd2, 2'b00, 2'b00, 2'b00, 2'b11};
      tbl[7] = '{1'b1, 2'b01, 2'b00, 2'd0, 2'b10, 2'b01, 2'b11, 2'b00};

      // Reset and quiet idle
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_outputs", 0, 32'({out_valid, out_y, out_y_t, out_xmask, out_id, busy}), 32'(0));
      apply_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("idle_ready", c, 32'({req0_ready, req1_ready}), 32'(0));
         chk("idle_outputs", c, 32'({out_valid, out_y, out_y_t, out_xmask, out_id, busy}), 32'(0));
      end

      // Directed table
      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].id, tbl[i].a, tbl[i].at, tbl[i].b, tbl[i].bt,
                tbl[i].ey, tbl[i].eyt, tbl[i].exm, i % 3, i);
      end

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         rid = 1'($urandom);
         ra  = W'($urandom);
         rat = W'($urandom);
         rb  = S'($urandom);
         rbt = S'($urandom_range(0, 3) == 0 ? $urandom : 0);
         model(ra, rat, rb, rbt, ry, ryt, rxm);
         run_op(rid, ra, rat, rb, rbt, ry, ryt, rxm, int'($urandom_range(0, 3)), 100 + i);
      end

      // Both requesters always valid, consumer always ready: strict alternation starting at 0
      apply_reset();
      out_ready = 1'b1;
      drive_req(1'b0, 1'b1, 2'b11, 2'b00, 2'd0, 2'b00);
      drive_req(1'b1, 1'b1, 2'b10, 2'b00, 2'd1, 2'b00);
      model(2'b11, 2'b00, 2'd0, 2'b00, e0y, e0yt, e0xm);
      model(2'b10, 2'b00, 2'd1, 2'b00, e1y, e1yt, e1xm);
      for (int c = 0; c < 12; c++) begin
         #1;
         if (req0_ready) begin g_id.push_back(0); g_cyc.push_back(c); end
         if (req1_ready) begin g_id.push_back(1); g_cyc.push_back(c); end
         if (out_valid) begin o_id.push_back(int'(out_id)); o_y.push_back(out_y); end
         if (c < 11) @(negedge clk);
      end
      drive_req(1'b0, 1'b0, '0, '0, '0, '0);
      drive_req(1'b1, 1'b0, '0, '0, '0, '0);
      chk("alt_grant_count", 0, 32'(g_id.size()), 32'(4));
      chk("alt_done_count", 0, 32'(o_id.size()), 32'(4));
      for (int i = 0; i < 4; i++) begin
         if (i < g_id.size()) chk("alt_grant_id", i, 32'(g_id[i]), 32'(i % 2));
         if (i > 0 && i < g_cyc.size()) chk("alt_grant_gap", i, 32'(g_cyc[i] - g_cyc[i-1]), 32'(3));
         if (i < o_id.size()) chk("alt_out_id", i, 32'(o_id[i]), 32'(i % 2));
         if (i < o_y.size()) chk("alt_out_y", i, 32'(o_y[i]), 32'((i % 2 == 1) ? e1y : e0y));
      end

      // Backpressure in DONE with both requesters waiting
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      drive_req(1'b0, 1'b1, 2'b10, 2'b01, 2'd0, 2'b00);
      drive_req(1'b1, 1'b1, 2'b11, 2'b00, 2'd1, 2'b00);
      #1;
      chk("bp_grant", 0, 32'({req0_ready, req1_ready}), 32'(2'b10));
      @(negedge clk);
      chk("bp_exec", 0, 32'({out_valid, req0_ready, req1_ready}), 32'(0));
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         chk("bp_hold_valid", s, 32'(out_valid), 32'(1));
         chk("bp_hold_out", s, 32'({out_y, out_y_t, out_xmask, out_id}), 32'({2'b10, 2'b01, 2'b00, 1'b0}));
         chk("bp_hold_ready", s, 32'({req0_ready, req1_ready}), 32'(0));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_next_grant", 0, 32'({req0_ready, req1_ready}), 32'(2'b01));
      chk("bp_next_valid", 0, 32'(out_valid), 32'(0));

      // Reset while requester 1's operation is in EXEC
      @(negedge clk);
      chk("rx_exec_busy", 0, 32'(busy), 32'(1));
      chk("rx_exec_hold_y", 0, 32'(out_y), 32'(2'b10));
      #1;
      rst_n = 1'b0;
      #1;
      chk("rx_outputs", 0, 32'({out_valid, out_y, out_y_t, out_xmask, out_id, busy}), 32'(0));
      chk("rx_ready", 0, 32'({req0_ready, req1_ready}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rx_first_grant", 0, 32'({req0_ready, req1_ready}), 32'(2'b10));
      @(posedge clk);
      #1;
      drive_req(1'b0, 1'b0, '0, '0, '0, '0);
      drive_req(1'b1, 1'b0, '0, '0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      chk("rx_drain_valid", 0, 32'(out_valid), 32'(1));
      chk("rx_drain_id", 0, 32'(out_id), 32'(0));
      chk("rx_drain_y", 0, 32'(out_y), 32'(2'b10));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
